bmd_256_latency_calc: RTL

Echo-latency calculator that sits directly downstream of the latency-check timestamp BRAM on its read port. On each echoed packet reported by RX_ENGINE it reads the start timestamp stored for that sequence tag and subtracts it from the free-running latency counter. It then publishes the per-packet latency and running statistics (count, min, max, sum) for VIO/ILA readout and host reporting.

---
 rtl/bmd_256_latency_calc.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bmd_256_latency_calc.sv
// Echo-latency calculator: looks up the start timestamp of each echoed tag in the
// timestamp BRAM, subtracts it from the arrival time, and keeps count/min/max/sum.
module bmd_256_latency_calc #(
  parameter int CNT_WIDTH  = 38,
  parameter int ADDR_WIDTH = 13,
  parameter int SUM_WIDTH  = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [CNT_WIDTH-1:0]  latency_counter,
  input  logic                  rx_echo_valid,
  input  logic [ADDR_WIDTH-1:0] rx_echo_tag,
  output logic                  rx_echo_ready,
  output logic                  bram_reb,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [CNT_WIDTH-1:0]  bram_rd_data,
  output logic                  lat_valid,
  output logic [CNT_WIDTH-1:0]  lat_value,
  output logic [31:0]           stat_count,
  output logic [CNT_WIDTH-1:0]  stat_min,
  output logic [CNT_WIDTH-1:0]  stat_max,
  output logic [SUM_WIDTH-1:0]  stat_sum,
  output logic                  seq_err
);

  localparam int WAIT_W = $clog2(RD_LATENCY) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 2);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [CNT_WIDTH-1:0]  r_arrival;
  logic [CNT_WIDTH-1:0]  r_lat_value;
  logic [31:0]           r_count;
  logic [CNT_WIDTH-1:0]  r_min;
  logic [CNT_WIDTH-1:0]  r_max;
  logic [SUM_WIDTH-1:0]  r_sum;
  logic [ADDR_WIDTH-1:0] r_exp_tag;
  logic                  r_seq_err;

  logic                  w_accept;
  logic [CNT_WIDTH-1:0]  w_lat;
  logic [SUM_WIDTH:0]    w_sum_full;

  assign rx_echo_ready = (r_state == IDLE) && !clear && !rst;
  assign w_accept      = rx_echo_ready && rx_echo_valid;
  // Modular subtraction keeps the result correct across a counter wrap.
  assign w_lat         = r_arrival - bram_rd_data;
  assign w_sum_full    = {1'b0, r_sum} + {{(SUM_WIDTH - CNT_WIDTH + 1){1'b0}}, w_lat};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = READ;
      READ: w_state_next = (RD_LATENCY == 1) ? CALC : WAIT;
      WAIT: if (r_wait_cnt == WAIT_LAST) w_state_next = CALC;
      CALC: w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_rd_addr   <= '0;
      r_arrival   <= '0;
      r_lat_value <= '0;
      r_count     <= '0;
      r_min       <= '1;
      r_max       <= '0;
      r_sum       <= '0;
      r_exp_tag   <= '0;
      r_seq_err   <= 1'b0;
    end else if (clear) begin
      r_count   <= '0;
      r_min     <= '1;
      r_max     <= '0;
      r_sum     <= '0;
      r_exp_tag <= '0;
      r_seq_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd_addr <= rx_echo_tag;
        r_arrival <= latency_counter;
        r_exp_tag <= rx_echo_tag + ADDR_WIDTH'(1);
        if (rx_echo_tag != r_exp_tag) r_seq_err <= 1'b1;
      end
      if (r_state == READ) r_wait_cnt <= '0;
      if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      // Statistics land on the edge into DONE so they are visible with lat_valid.
      if (r_state == CALC) begin
        r_lat_value <= w_lat;
        if (r_count != '1) r_count <= r_count + 32'd1;
        r_sum <= w_sum_full[SUM_WIDTH] ? '1 : w_sum_full[SUM_WIDTH-1:0];
        if (w_lat < r_min) r_min <= w_lat;
        if (w_lat > r_max) r_max <= w_lat;
      end
    end
  end

  assign bram_reb     = (r_state == READ);
  assign bram_rd_addr = r_rd_addr;
  assign lat_valid    = (r_state == DONE);
  assign lat_value    = r_lat_value;
  assign stat_count   = r_count;
  assign stat_min     = r_min;
  assign stat_max     = r_max;
  assign stat_sum     = r_sum;
  assign seq_err      = r_seq_err;

endmodule
